// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared FSM state type and select-decode helper for scan_decoder
// Optional feature macro: SCAN_DECODER_BLANK_EN (BLANK state only reachable when defined)
// Contents: state_t enum, onehot_hit() single-bit decode function
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } state_t;

   // One output bit of a one-hot decode: bit i is hot when the full address equals i.
   // Comparing the whole address means out-of-range addresses never alias onto a low bit.
   function automatic logic onehot_hit(input logic [31:0] a, input logic [31:0] i);
      return (a == i);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational index-to-select one-hot decoder
// Ports:
//   a   in  AW    index to decode (values >= NOUT decode to all-zero)
//   en  in  1     0 forces all outputs low
//   y   out NOUT  one-hot (or all-zero) select
module onehot_decoder
   import scan_decoder_pkg::*;
#(
   parameter int AW   = 5,
   parameter int NOUT = 24
) (
   input  logic [AW-1:0]   a,
   input  logic            en,
   output logic [NOUT-1:0] y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < NOUT; i++) begin
         y[i] = en & onehot_hit(32'(a), 32'(i));
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - direct-decode / auto-scan one-hot select generator
// Optional feature macro: SCAN_DECODER_BLANK_EN (one all-zero BLANK cycle on every nonzero select change)
// Ports:
//   clk         in  1     rising-edge clock
//   rst_n       in  1     asynchronous active-low reset
//   en          in  1     global enable, 0 forces idle
//   mode        in  1     0 = direct decode, 1 = auto-scan
//   addr_valid  in  1     direct-mode address offered
//   addr        in  AW    direct-mode address
//   addr_ready  out 1     address accepted this cycle
//   period      in  PW    scan dwell length minus one
//   sel         out NOUT  registered one-hot (or all-zero) select
//   sel_idx     out AW    index of the asserted select bit
//   wrap        out 1     pulse when the scan returns to index 0
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int AW   = 5,
   parameter int NOUT = 24,
   parameter int PW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            mode,
   input  logic            addr_valid,
   input  logic [AW-1:0]   addr,
   output logic            addr_ready,
   input  logic [PW-1:0]   period,
   output logic [NOUT-1:0] sel,
   output logic [AW-1:0]   sel_idx,
   output logic            wrap
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NOUT - 1);

   state_t          state, state_n;
   logic [PW-1:0]   cnt, cnt_n;
   logic [AW-1:0]   idx_n, idx_inc;
   logic            drv, drv_n;          // sel is driven from sel_idx
   logic            from_scan, from_scan_n;  // which state a BLANK returns to
   logic            wrap_n;
   logic            xfer;
   logic            blank_en;
   logic [NOUT-1:0] sel_n;

`ifdef SCAN_DECODER_BLANK_EN
   assign blank_en = 1'b1;
`else
   assign blank_en = 1'b0;
`endif

   assign addr_ready = (state == DIRECT);
   assign xfer       = addr_ready & addr_valid;
   assign idx_inc    = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = sel_idx;
      drv_n       = drv;
      from_scan_n = from_scan;
      wrap_n      = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
         drv_n   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt_n   = '0;
               idx_n   = '0;
               drv_n   = mode;
               state_n = mode ? SCAN : DIRECT;
            end
            DIRECT: begin
               if (mode) begin
                  state_n = SCAN;
                  idx_n   = '0;
                  cnt_n   = '0;
                  drv_n   = 1'b1;
               end else if (xfer) begin
                  idx_n = addr;
                  drv_n = 1'b1;
                  // Only a visible select that actually changes needs the gap.
                  if (blank_en && (sel != '0) && (addr != sel_idx)) begin
                     state_n     = BLANK;
                     drv_n       = 1'b0;
                     from_scan_n = 1'b0;
                  end
               end
            end
            SCAN: begin
               if (!mode) begin
                  state_n = DIRECT;
                  idx_n   = '0;
                  cnt_n   = '0;
                  drv_n   = 1'b0;
               end else if (cnt >= period) begin
                  // >= so a period lowered mid-dwell advances immediately
                  idx_n = idx_inc;
                  cnt_n = '0;
                  if (blank_en) begin
                     state_n     = BLANK;
                     drv_n       = 1'b0;
                     from_scan_n = 1'b1;
                  end else begin
                     wrap_n = (idx_inc == '0);
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            BLANK: begin
               // sel_idx already holds the upcoming index; dwell count is frozen here.
               drv_n = 1'b1;
               if (mode && from_scan) begin
                  state_n = SCAN;
                  wrap_n  = (sel_idx == '0);
               end else if (mode) begin
                  state_n = SCAN;
                  idx_n   = '0;
                  cnt_n   = '0;
               end else begin
                  state_n = DIRECT;
                  if (from_scan) begin
                     idx_n = '0;
                     drv_n = 1'b0;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   onehot_decoder #(.AW(AW), .NOUT(NOUT)) u_dec (
      .a  (idx_n),
      .en (drv_n),
      .y  (sel_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_idx   <= '0;
         drv       <= 1'b0;
         from_scan <= 1'b0;
         wrap      <= 1'b0;
         sel       <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sel_idx   <= idx_n;
         drv       <= drv_n;
         from_scan <= from_scan_n;
         wrap      <= wrap_n;
         sel       <= sel_n;
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder
module tb_scan_decoder;

   localparam int AW   = 5;
   localparam int NOUT = 24;
   localparam int PW   = 16;
`ifdef SCAN_DECODER_BLANK_EN
   localparam int BL = 1;
`else
   localparam int BL = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            en = 1'b0;
   logic            mode = 1'b0;
   logic            addr_valid = 1'b0;
   logic [AW-1:0]   addr = '0;
   logic [PW-1:0]   period = '0;
   logic            addr_ready;
   logic [NOUT-1:0] sel;
   logic [AW-1:0]   sel_idx;
   logic            wrap;

   int n_cmp = 0;
   int n_bad = 0;
   int last_a = 0;

   always #5 clk = ~clk;

   scan_decoder #(.AW(AW), .NOUT(NOUT), .PW(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .addr_valid (addr_valid),
      .addr       (addr),
      .addr_ready (addr_ready),
      .period     (period),
      .sel        (sel),
      .sel_idx    (sel_idx),
      .wrap       (wrap)
   );

   function automatic logic [31:0] onehot_of(input int a);
      if (a >= 0 && a < NOUT) return 32'(1) << a;
      return 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(sel) <= 1), 32'd1);
   endtask

   task automatic direct_xfer(input int a);
      logic [31:0] prev_sel;
      int          prev_idx;
      bit          blank;
      prev_sel = 32'(sel);
      prev_idx = int'(sel_idx);
      chk("dir_ready", 32'(addr_ready), 32'd1);
      addr       = AW'(a);
      addr_valid = 1'b1;
      tick;
      addr_valid = 1'b0;
      addr       = AW'($urandom);
      blank = (BL == 1) && (prev_sel != 0) && (a != prev_idx);
      if (blank) begin
         chk("dir_blank_sel", 32'(sel), 32'd0);
         chk("dir_blank_ready", 32'(addr_ready), 32'd0);
         tick;
      end
      chk("dir_sel", 32'(sel), onehot_of(a));
      chk("dir_idx", 32'(sel_idx), 32'(a));
      last_a = a;
   endtask

   // Enter with the first SCAN cycle visible. Expected index after k cycles follows
   // directly from the dwell length: each slot is P+1 visible cycles (+1 blank).
   task automatic run_scan(input int p, input int ncyc, output int wraps);
      int slot, pos, i;
      slot  = p + 1 + BL;
      wraps = 0;
      for (int k = 0; k < ncyc; k++) begin
         pos = k % slot;
         if (pos > p) begin
            chk("scan_blank_sel", 32'(sel), 32'd0);
            chk("scan_wrap_blank", 32'(wrap), 32'd0);
         end else begin
            i = (k / slot) % NOUT;
            chk("scan_sel", 32'(sel), onehot_of(i));
            chk("scan_idx", 32'(sel_idx), 32'(i));
            chk("scan_wrap", 32'(wrap), 32'(k >= slot && pos == 0 && i == 0));
         end
         chk("scan_ready", 32'(addr_ready), 32'd0);
         if (wrap) wraps++;
         addr_valid = 1'($urandom);
         addr       = AW'($urandom);
         tick;
      end
      addr_valid = 1'b0;
   endtask

   initial begin
      int w, p, gap, t;

      #1 rst_n = 1'b0;
      #1;
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_idx", 32'(sel_idx), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_ready", 32'(addr_ready), 32'd0);

      // release mid-cycle with en already high: nothing moves until the next edge
      #21;
      en    = 1'b1;
      mode  = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel_ready_before_edge", 32'(addr_ready), 32'd0);
      tick;
      chk("direct_entry_ready", 32'(addr_ready), 32'd1);
      chk("direct_entry_sel", 32'(sel), 32'd0);

      direct_xfer(5);
      direct_xfer(23);
      repeat (3) tick;
      chk("direct_hold_sel", 32'(sel), onehot_of(23));
      direct_xfer(27);
      chk("oor_sel_zero", 32'(sel), 32'd0);

      repeat (20) begin
         gap = $urandom_range(0, 3);
         repeat (gap) tick;
         chk("direct_hold_rand", 32'(sel), onehot_of(last_a));
         direct_xfer($urandom_range(0, 31));
      end

      // auto-scan, period 2: 72-cycle rotation with one wrap each
      period = PW'(2);
      mode   = 1'b1;
      tick;
      run_scan(2, 2 * NOUT * (3 + BL) + 5, w);
      chk("scan_p2_wraps", 32'(w), 32'd2);

      repeat (3) begin
         p      = $urandom_range(0, 4);
         period = PW'(p);
         mode   = 1'b0;
         tick;
         chk("toggle_direct_sel", 32'(sel), 32'd0);
         chk("toggle_direct_ready", 32'(addr_ready), 32'd1);
         mode = 1'b1;
         tick;
         run_scan(p, NOUT * (p + 1 + BL) + 3, w);
         chk("scan_rand_wraps", 32'(w), 32'd1);
      end

      // period lowered mid-dwell takes effect at once
      mode = 1'b0;
      tick;
      period = PW'(5);
      mode   = 1'b1;
      tick;
      tick;
      tick;
      chk("dwell_before_change", 32'(sel_idx), 32'd0);
      period = PW'(1);
      tick;
      if (BL == 1) begin
         chk("dwell_change_blank", 32'(sel), 32'd0);
         tick;
      end
      chk("dwell_change_idx", 32'(sel_idx), 32'd1);
      chk("dwell_change_sel", 32'(sel), onehot_of(1));

      // drop en mid-scan at index 10, then restart
      mode = 1'b0;
      tick;
      period = '0;
      mode   = 1'b1;
      tick;
      t = 0;
      while (!(sel_idx == AW'(10) && sel != '0) && t < 200) begin
         tick;
         t++;
      end
      chk("reach_idx10", 32'(t < 200), 32'd1);
      en = 1'b0;
      tick;
      chk("en_off_sel", 32'(sel), 32'd0);
      chk("en_off_idx", 32'(sel_idx), 32'd0);
      chk("en_off_ready", 32'(addr_ready), 32'd0);
      tick;
      chk("en_off_sel2", 32'(sel), 32'd0);
      chk("en_off_wrap", 32'(wrap), 32'd0);
      en = 1'b1;
      tick;
      chk("restart_sel", 32'(sel), onehot_of(0));
      chk("restart_idx", 32'(sel_idx), 32'd0);
      chk("restart_wrap", 32'(wrap), 32'd0);

      // asynchronous reset between edges during scan
      tick;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_sel", 32'(sel), 32'd0);
      chk("async_rst_idx", 32'(sel_idx), 32'd0);
      chk("async_rst_wrap", 32'(wrap), 32'd0);
      chk("async_rst_ready", 32'(addr_ready), 32'd0);
      mode = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
      chk("rel2_ready_before_edge", 32'(addr_ready), 32'd0);
      tick;
      chk("rel2_direct_ready", 32'(addr_ready), 32'd1);
      chk("rel2_direct_sel", 32'(sel), 32'd0);
      direct_xfer($urandom_range(0, NOUT - 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
